ysyx_25040109_mem_arbiter: RTL and testbench

Shares the single memory port between the instruction fetch master (IFU, read-only) and the data master (LSU, read/write).
- Allows one outstanding transaction at a time: arbitrate, latch the request, issue it to memory, route the response back to its owner.
- Sits between the CPU's fetch/access channels and the MEM model.
- Includes a response timeout that returns an error so a hung slave cannot deadlock the core.

---
 rtl/ysyx_25040109_mem_arbiter_pkg.sv | 19 +
 rtl/ysyx_25040109_arb2.sv | 34 +++
 rtl/ysyx_25040109_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ysyx_25040109_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040109_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM state encoding,
// owner codes and arbitration mode selectors.
package ysyx_25040109_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  // Owner / grant codes, also the encoding of the top-level owner output.
  localparam logic OwnIfu = 1'b0;
  localparam logic OwnLsu = 1'b1;

  // Arbitration modes.
  localparam int unsigned ArbRoundRobin = 0;
  localparam int unsigned ArbFixedLsu   = 1;

endpackage

// File: rtl/ysyx_25040109_arb2.sv
// Two-way combinational grant between IFU and LSU.
//   ifu_req_i / lsu_req_i : request lines
//   last_grant_i          : master granted most recently (OwnIfu / OwnLsu)
//   ifu_gnt_o / lsu_gnt_o : one-hot (or zero) grant
// ArbMode selects round-robin (tie goes to the master that was not granted
// last) or fixed priority with LSU winning every tie.
module ysyx_25040109_arb2
  import ysyx_25040109_mem_arbiter_pkg::*;
#(
  parameter int unsigned ArbMode = ArbRoundRobin
) (
  input  logic ifu_req_i,
  input  logic lsu_req_i,
  input  logic last_grant_i,
  output logic ifu_gnt_o,
  output logic lsu_gnt_o
);

  always_comb begin
    ifu_gnt_o = 1'b0;
    lsu_gnt_o = 1'b0;
    if (ifu_req_i && lsu_req_i) begin
      if ((ArbMode == ArbFixedLsu) || (last_grant_i == OwnIfu)) begin
        lsu_gnt_o = 1'b1;
      end else begin
        ifu_gnt_o = 1'b1;
      end
    end else begin
      ifu_gnt_o = ifu_req_i;
      lsu_gnt_o = lsu_req_i;
    end
  end

endmodule

// File: rtl/ysyx_25040109_mem_arbiter.sv
// Memory-port arbiter between the instruction fetch master (IFU, read-only)
// and the data master (LSU, read/write). One transaction is outstanding at a
// time: arbitrate in IDLE, latch the winner's request, present it to memory in
// ISSUE until accepted, then forward the response to the owner in WAIT.
// A response timeout returns an error so a silent slave cannot hang the core.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   i_*               : IFU request (valid/ready/addr) and response channel
//   d_*               : LSU request (valid/ready/wen/addr/wdata/wlen) and response
//   m_*               : single memory port (request handshake + response)
//   busy              : a transaction is in flight
//   owner             : current or most recent grant (0 = IFU, 1 = LSU)
module ysyx_25040109_mem_arbiter
  import ysyx_25040109_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  // IFU
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp_err,
  // LSU
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_wlen,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp_err,
  // Memory
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [2:0]        m_wlen,
  input  logic              m_resp_valid,
  input  logic [DATA_W-1:0] m_rdata,
  // Status
  output logic              busy,
  output logic              owner
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        wlen_q, wlen_d;

  logic              ifu_gnt, lsu_gnt;
  logic              tmo_hit;
  logic              resp_fire, resp_err;
  logic [DATA_W-1:0] resp_data;

  ysyx_25040109_arb2 #(
    .ArbMode (ARB_MODE)
  ) u_arb2 (
    .ifu_req_i    (i_req_valid),
    .lsu_req_i    (d_req_valid),
    .last_grant_i (last_grant_q),
    .ifu_gnt_o    (ifu_gnt),
    .lsu_gnt_o    (lsu_gnt)
  );

  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wlen_d       = wlen_q;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    m_req_valid  = 1'b0;
    resp_fire    = 1'b0;
    resp_err     = 1'b0;
    resp_data    = '0;

    case (state_q)
      StIdle: begin
        // Readies are gated by reset so every output is low while held in reset.
        i_req_ready = rst & ifu_gnt;
        d_req_ready = rst & lsu_gnt;
        if (d_req_ready && d_req_valid) begin
          wen_d        = d_wen;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          wlen_d       = d_wlen;
          owner_d      = OwnLsu;
          last_grant_d = OwnLsu;
          cnt_d        = '0;
          state_d      = StIssue;
        end else if (i_req_ready && i_req_valid) begin
          wen_d        = 1'b0;
          addr_d       = i_addr;
          wdata_d      = '0;
          wlen_d       = 3'd0;
          owner_d      = OwnIfu;
          last_grant_d = OwnIfu;
          cnt_d        = '0;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d = cnt_q + CntW'(1);
        // Responses seen here belong to nothing in flight and are dropped.
        if (tmo_hit) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
          state_d   = StIdle;
        end else begin
          m_req_valid = 1'b1;
          if (m_req_ready) begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        // A real response in the expiry cycle takes precedence over the timeout.
        if (m_resp_valid) begin
          resp_fire = 1'b1;
          resp_data = m_rdata;
          state_d   = StIdle;
        end else if (tmo_hit) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnIfu;
      last_grant_q <= OwnIfu;
      cnt_q        <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wlen_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wlen_q       <= wlen_d;
    end
  end

  assign i_resp_valid = resp_fire & (owner_q == OwnIfu);
  assign i_resp_err   = resp_err & (owner_q == OwnIfu);
  assign i_rdata      = (owner_q == OwnIfu) ? resp_data : '0;
  assign d_resp_valid = resp_fire & (owner_q == OwnLsu);
  assign d_resp_err   = resp_err & (owner_q == OwnLsu);
  assign d_rdata      = (owner_q == OwnLsu) ? resp_data : '0;

  assign m_wen   = wen_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_wlen  = wlen_q;

  assign busy  = (state_q != StIdle);
  assign owner = owner_q;

endmodule

// File: tb/tb_ysyx_25040109_mem_arbiter.sv
// Bench for the memory arbiter: a round-robin instance with an 8-cycle timeout
// carries most of the directed traffic, a fixed-priority instance checks ties.
module tb_ysyx_25040109_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req_valid, d_req_ready, d_wen, d_resp_valid, d_resp_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_wlen;
  logic        m_req_valid, m_req_ready, m_wen, m_resp_valid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_wlen;
  logic        busy, owner;

  // Fixed-priority instance
  logic        b_i_req_valid, b_i_req_ready, b_i_resp_valid, b_i_resp_err;
  logic [31:0] b_i_addr, b_i_rdata;
  logic        b_d_req_valid, b_d_req_ready, b_d_wen, b_d_resp_valid, b_d_resp_err;
  logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic [2:0]  b_d_wlen;
  logic        b_m_req_valid, b_m_req_ready, b_m_wen, b_m_resp_valid;
  logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;
  logic [2:0]  b_m_wlen;
  logic        b_busy, b_owner;

  ysyx_25040109_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(8)
  ) u_dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_wen(d_wen),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wlen(d_wlen),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_resp_err(d_resp_err),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_wen(m_wen),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wlen(m_wlen),
    .m_resp_valid(m_resp_valid), .m_rdata(m_rdata),
    .busy(busy), .owner(owner)
  );

  ysyx_25040109_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(8)
  ) u_dut_fixed (
    .clk(clk), .rst(rst),
    .i_req_valid(b_i_req_valid), .i_req_ready(b_i_req_ready), .i_addr(b_i_addr),
    .i_resp_valid(b_i_resp_valid), .i_rdata(b_i_rdata), .i_resp_err(b_i_resp_err),
    .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready), .d_wen(b_d_wen),
    .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_wlen(b_d_wlen),
    .d_resp_valid(b_d_resp_valid), .d_rdata(b_d_rdata), .d_resp_err(b_d_resp_err),
    .m_req_valid(b_m_req_valid), .m_req_ready(b_m_req_ready), .m_wen(b_m_wen),
    .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_wlen(b_m_wlen),
    .m_resp_valid(b_m_resp_valid), .m_rdata(b_m_rdata),
    .busy(b_busy), .owner(b_owner)
  );

  typedef struct {
    logic        lsu;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for the round-robin instance.
  always @(negedge clk) begin
    if (i_resp_valid === 1'b1 || d_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: i_resp_valid=%0b d_resp_valid=%0b, none expected (t=%0t)",
                 i_resp_valid, d_resp_valid, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_both", {31'd0, i_resp_valid & d_resp_valid}, 32'd0);
        chk("resp_owner", {31'd0, d_resp_valid}, {31'd0, mon_e.lsu});
        chk("resp_err", {31'd0, d_resp_valid ? d_resp_err : i_resp_err}, {31'd0, mon_e.err});
        if (mon_e.chk_data) chk("resp_rdata", d_resp_valid ? d_rdata : i_rdata, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic accept_ifu(input logic [31:0] addr);
    i_req_valid = 1'b1;
    i_addr      = addr;
    @(negedge clk);
    chk("i_req_ready", i_req_ready, 1);
    chk("d_req_ready_idle", d_req_ready, 0);
    tick();
    i_req_valid = 1'b0;
  endtask

  task automatic accept_lsu(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] wlen);
    d_req_valid = 1'b1;
    d_wen       = wen;
    d_addr      = addr;
    d_wdata     = wdata;
    d_wlen      = wlen;
    @(negedge clk);
    chk("d_req_ready", d_req_ready, 1);
    chk("i_req_ready_idle", i_req_ready, 0);
    tick();
    d_req_valid = 1'b0;
  endtask

  // Called in ISSUE: hold ready low for ready_delay cycles, wait resp_delay
  // cycles in WAIT, then respond with rdata.
  task automatic mem_serve(input int ready_delay, input int resp_delay, input logic [31:0] rdata,
                           input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] wlen);
    for (int c = 0; c <= ready_delay; c++) begin
      m_req_ready = (c == ready_delay);
      @(negedge clk);
      chk("m_req_valid", m_req_valid, 1);
      chk("m_wen", m_wen, wen);
      chk("m_addr", m_addr, addr);
      chk("m_wdata", m_wdata, wdata);
      chk("m_wlen", m_wlen, wlen);
      tick();
    end
    m_req_ready = 1'b0;
    for (int c = 0; c < resp_delay; c++) begin
      @(negedge clk);
      chk("m_req_valid_wait", m_req_valid, 0);
      chk("busy_wait", busy, 1);
      tick();
    end
    m_resp_valid = 1'b1;
    m_rdata      = rdata;
    tick();
    m_resp_valid = 1'b0;
    m_rdata      = 32'h0;
    @(negedge clk);
    chk("busy_after_resp", busy, 0);
    tick();
  endtask

  // Called in ISSUE. The 8th cycle after accept is the expiry cycle.
  task automatic tmo_probe(input logic lsu, input logic give_ready, input logic resp_at_end,
                           input logic [31:0] rdata);
    for (int t = 1; t <= 8; t++) begin
      m_req_ready = give_ready && (t == 1);
      if (t == 8 && resp_at_end) begin
        m_resp_valid = 1'b1;
        m_rdata      = rdata;
      end
      @(negedge clk);
      chk(t < 8 ? "tmo_no_early_resp" : "tmo_resp_valid", lsu ? d_resp_valid : i_resp_valid,
          (t == 8) ? 32'd1 : 32'd0);
      chk("tmo_m_req_valid", m_req_valid,
          (t == 8) ? 32'd0 : (give_ready ? ((t == 1) ? 32'd1 : 32'd0) : 32'd1));
      tick();
    end
    m_req_ready  = 1'b0;
    // A late response in IDLE must not reach either master.
    m_resp_valid = 1'b1;
    m_rdata      = 32'hBAD0BAD0;
    @(negedge clk);
    chk("tmo_idle_busy", busy, 0);
    chk("late_i_resp", i_resp_valid, 0);
    chk("late_d_resp", d_resp_valid, 0);
    tick();
    m_resp_valid = 1'b0;
    m_rdata      = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    i_req_valid  = 1'b1;
    i_addr       = 32'h80000000;
    d_req_valid  = 1'b1;
    d_wen        = 1'b1;
    d_addr       = 32'h80000004;
    d_wdata      = 32'h11111111;
    d_wlen       = 3'd1;
    m_req_ready  = 1'b0;
    m_resp_valid = 1'b0;
    m_rdata      = 32'h0;
    b_i_req_valid = 1'b0; b_i_addr = 32'h80000000;
    b_d_req_valid = 1'b0; b_d_wen = 1'b0; b_d_addr = 32'h80000800;
    b_d_wdata = 32'h0; b_d_wlen = 3'd0;
    b_m_req_ready = 1'b0; b_m_resp_valid = 1'b0; b_m_rdata = 32'h0;

    // Reset state with requests pending: everything low.
    #2;
    chk("rst_i_req_ready", i_req_ready, 0);
    chk("rst_d_req_ready", d_req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wen", m_wen, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wlen", m_wlen, 0);
    chk("rst_i_resp_valid", i_resp_valid, 0);
    chk("rst_d_resp_valid", d_resp_valid, 0);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Fixed priority: LSU wins every tie; responses in ISSUE are ignored.
    b_i_req_valid  = 1'b1;
    b_d_req_valid  = 1'b1;
    b_m_req_ready  = 1'b1;
    b_m_resp_valid = 1'b1;
    b_m_rdata      = 32'h00005A5A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fix_d_req_ready", b_d_req_ready, 1);
      chk("fix_i_req_ready", b_i_req_ready, 0);
      tick();
      @(negedge clk);
      chk("fix_m_req_valid", b_m_req_valid, 1);
      chk("fix_issue_resp_ignored", b_d_resp_valid, 0);
      tick();
      @(negedge clk);
      chk("fix_d_resp_valid", b_d_resp_valid, 1);
      chk("fix_i_resp_valid", b_i_resp_valid, 0);
      chk("fix_d_rdata", b_d_rdata, 32'h00005A5A);
      tick();
    end
    b_i_req_valid  = 1'b0;
    b_d_req_valid  = 1'b0;
    b_m_resp_valid = 1'b0;

    // Round-robin ties right after reset: LSU, IFU, LSU, IFU.
    for (int k = 0; k < 4; k++) begin
      i_req_valid = 1'b1;
      i_addr      = 32'h80000100;
      d_req_valid = 1'b1;
      d_wen       = 1'b1;
      d_addr      = 32'h80002000;
      d_wdata     = 32'hCAFEF00D;
      d_wlen      = 3'd4;
      @(negedge clk);
      chk("tie_d_req_ready", d_req_ready, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("tie_i_req_ready", i_req_ready, (k % 2 == 0) ? 32'd0 : 32'd1);
      exp_q.push_back('{lsu: (k % 2 == 0), data: 32'h1000 + k, err: 1'b0,
                        chk_data: (k % 2 != 0)});
      tick();
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      if (k % 2 == 0) mem_serve(0, 0, 32'h1000 + k, 1'b1, 32'h80002000, 32'hCAFEF00D, 3'd4);
      else            mem_serve(0, 0, 32'h1000 + k, 1'b0, 32'h80000100, 32'h0, 3'd0);
    end
    chk("tie_drained", exp_q.size(), 0);

    // IFU read, memory ready at once, response two cycles later.
    d_wen = 1'b0; d_wdata = 32'h0; d_wlen = 3'd0;
    exp_q.push_back('{lsu: 1'b0, data: 32'h00000413, err: 1'b0, chk_data: 1'b1});
    accept_ifu(32'h80000000);
    mem_serve(0, 1, 32'h00000413, 1'b0, 32'h80000000, 32'h0, 3'd0);
    chk("ifu_read_drained", exp_q.size(), 0);

    // LSU write with memory stalling 5 cycles.
    exp_q.push_back('{lsu: 1'b1, data: 32'h0, err: 1'b0, chk_data: 1'b0});
    accept_lsu(1'b1, 32'h80001000, 32'hDEADBEEF, 3'd2);
    mem_serve(5, 0, 32'h0, 1'b1, 32'h80001000, 32'hDEADBEEF, 3'd2);
    chk("lsu_write_drained", exp_q.size(), 0);

    // Timeout in WAIT (IFU), then timeout in ISSUE (LSU, never accepted).
    exp_q.push_back('{lsu: 1'b0, data: 32'h0, err: 1'b1, chk_data: 1'b1});
    accept_ifu(32'h80000010);
    tmo_probe(1'b0, 1'b1, 1'b0, 32'h0);
    chk("tmo_wait_drained", exp_q.size(), 0);
    exp_q.push_back('{lsu: 1'b1, data: 32'h0, err: 1'b1, chk_data: 1'b1});
    accept_lsu(1'b0, 32'h80004000, 32'h0, 3'd0);
    tmo_probe(1'b1, 1'b0, 1'b0, 32'h0);
    chk("tmo_issue_drained", exp_q.size(), 0);

    // Response in the expiry cycle wins over the timeout.
    exp_q.push_back('{lsu: 1'b0, data: 32'h12345678, err: 1'b0, chk_data: 1'b1});
    accept_ifu(32'h80000020);
    tmo_probe(1'b0, 1'b1, 1'b1, 32'h12345678);
    chk("tmo_race_drained", exp_q.size(), 0);

    // Asynchronous reset during WAIT: no response is delivered.
    accept_lsu(1'b0, 32'h80003000, 32'h0, 3'd0);
    m_req_ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_m_req_valid", m_req_valid, 1);
    tick();
    m_req_ready = 1'b0;
    #2;
    chk("pre_rst_busy", busy, 1);
    rst          = 1'b0;
    m_resp_valid = 1'b1;
    m_rdata      = 32'h00000077;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_req_valid", m_req_valid, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_m_addr", m_addr, 0);
    chk("mid_rst_d_resp_valid", d_resp_valid, 0);
    tick();
    m_resp_valid = 1'b0;
    m_rdata      = 32'h0;
    rst          = 1'b1;
    exp_q.push_back('{lsu: 1'b0, data: 32'hABCD0001, err: 1'b0, chk_data: 1'b1});
    accept_ifu(32'h80000040);
    mem_serve(1, 1, 32'hABCD0001, 1'b0, 32'h80000040, 32'h0, 3'd0);
    chk("post_rst_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
